// File: rtl/sync_fifo_flagged_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_flagged.
// The master side drives write/read requests and error clear; the slave side
// (the FIFO) returns data, flags, occupancy and sticky error status.
interface sync_fifo_flagged_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 1024
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  wr_en_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  full_o;
   logic                  almost_full_o;
   logic                  rd_en_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  valid_o;
   logic                  empty_o;
   logic                  almost_empty_o;
   logic [ADDR_WIDTH:0]   count_o;
   logic                  clr_err_i;
   logic                  overflow_o;
   logic                  underflow_o;

   modport master (
      output wr_en_i, data_i, rd_en_i, clr_err_i,
      input  full_o, almost_full_o, data_o, valid_o, empty_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );

   modport slave (
      input  wr_en_i, data_i, rd_en_i, clr_err_i,
      output full_o, almost_full_o, data_o, valid_o, empty_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock circular FIFO with registered full/empty/almost flags,
// occupancy count and sticky overflow/underflow errors. FWFT selects between
// a registered-read output and a first-word-fall-through output.
module sync_fifo_flagged #(
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 1024,
   parameter int ADDR_WIDTH    = $clog2(DEPTH),
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4,
   parameter int FWFT          = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   sync_fifo_flagged_if.slave bus
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   typedef logic [ADDR_WIDTH:0] ptr_t;

   localparam ptr_t PTR_ONE    = ptr_t'(1);
   localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ptr_t wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   ptr_t count_q, count_d;
   logic full_q, empty_q, afull_q, aempty_q;
   logic full_d, empty_d, afull_d, aempty_d;
   logic overflow_q, underflow_q;
   logic wr_acc, rd_acc;

   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   // Acceptance and next-state pointer/flag computation from current-cycle flags.
   always_comb begin
      // NOTE: every variable gets a value on every path here, otherwise a latch is inferred.
      wr_acc   = bus.wr_en_i && !full_q;
      rd_acc   = bus.rd_en_i && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = wr_ptr_d - rd_ptr_d;
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                 (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
      afull_d  = (count_d >= AFULL_LVL);
      aempty_d = (count_d <= AEMPTY_LVL);
   end

   // Pointer, occupancy, flag and sticky error registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         // Setting wins over a coincident clear.
         overflow_q  <= (bus.wr_en_i && full_q)  || (overflow_q  && !bus.clr_err_i);
         underflow_q <= (bus.rd_en_i && empty_q) || (underflow_q && !bus.clr_err_i);
      end
   end

   // Storage write on accepted writes.
   always_ff @(posedge clk_i) begin
      // NOTE: the storage array has no reset; stale contents are unreachable once pointers reset.
      if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_i;
   end

   if (FWFT != 0) begin : g_fwft
      // Head word presented directly from storage; forced to zero while empty.
      always_comb begin
         rd_valid = !empty_q;
         rd_data  = empty_q ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
   end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // Registered read: data captured on an accepted read, valid for one cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         end
      end

      assign rd_data  = data_q;
      assign rd_valid = valid_q;
   end

   assign bus.data_o         = rd_data;
   assign bus.valid_o        = rd_valid;
   assign bus.full_o         = full_q;
   assign bus.almost_full_o  = afull_q;
   assign bus.empty_o        = empty_q;
   assign bus.almost_empty_o = aempty_q;
   assign bus.count_o        = count_q;
   assign bus.overflow_o     = overflow_q;
   assign bus.underflow_o    = underflow_q;

endmodule
